load_store_unit: RTL and testbench
==================================

# load_store_unit

Execute-stage memory unit that sits directly downstream of the ALU/branch execute stage. It takes the computed effective address (`arch_reg`, 32 bits) plus store data and load/store width, and drives a single-outstanding word-wide memory bus with byte enables. It returns load data, already sign- or zero-extended, to writeback as a one-cycle result pulse with a fault indication. Misaligned accesses, illegal widths and bus timeouts raise faults.

## Interface
- `TIMEOUT_CYCLES`, default 16: bus cycles without `mem_ack` before a timeout fault; legal range 2..255.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; combinational, high only in IDLE with `reset_n` high.
- `req_addr` in 32: effective address (execute result).
- `req_wdata` in 32: store data (rs2 value).
- `req_is_store` in 1: 1 means store, 0 means load.
- `req_funct3` in 3: RV32I width field (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_rd` in 5: load destination register.
- `rsp_valid` out 1: one-cycle result pulse; no backpressure.
- `rsp_rd` out 5: destination; 0 for stores and faults.
- `rsp_data` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: access faulted.
- `rsp_cause` out 2: 00 none, 01 misaligned, 10 bus timeout, 11 illegal width.
- `mem_req` out 1: bus request; held until ack or timeout.
- `mem_we` out 1: write strobe.
- `mem_addr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables; `4'b0000` on loads.
- `mem_ack` in 1: bus completion, single cycle.
- `mem_rdata` in 32: read data, valid with `mem_ack`.

## Operation
- FSM states are IDLE, BUS and RESP. All registered outputs reset to 0 and the state resets to IDLE.
- **IDLE**: on `req_valid && req_ready`, capture addr, wdata, store, funct3 and rd, then decode:
  - Illegal width: store funct3 ∉ {000,001,010}, or load funct3 ∈ {011,110,111}. Go to RESP with cause 11; no bus cycle.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0, when the macro is enabled. Go to RESP with cause 01; no bus cycle.
  - Otherwise go to BUS and assert `mem_req`. The timeout counter is cleared.
- **BUS**: `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stay stable.
  - On `mem_ack`, latch the formatted result and go to RESP.
  - Otherwise increment the counter. At count `TIMEOUT_CYCLES-1` with no ack, go to RESP with cause 10.
  - If `mem_ack` arrives in the expiry cycle, the ack wins and there is no fault.
- **RESP**: `rsp_valid`=1 for exactly one cycle, then return to IDLE. `mem_req`=0.
- Store formatting:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{wdata[15:0]}}`.
  - SW: `be = 4'b1111`, wdata unchanged.
- Load formatting:
  - Byte lane is `rdata >> (8*addr[1:0])`; halfword lane is `rdata >> (16*addr[1])`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes `rdata` through.
- Reset mid-operation: `reset_n` low in any state forces IDLE at the next edge, drops `mem_req`, and produces no `rsp_valid`. A late `mem_ack` in IDLE is ignored.

## Timing
- Latency, accept to `rsp_valid`:
  - Bus access: 2 cycles + ack wait. Accept at cycle 0, `mem_req` high at cycle 1, ack at cycle 1, `rsp_valid` at cycle 2.
  - Fault without a bus cycle: `rsp_valid` at cycle 1.
  - Timeout: `rsp_valid` at cycle `TIMEOUT_CYCLES+1`.
- Throughput: one access in flight; `req_ready` is low from cycle 1 until the cycle after the RESP pulse.
- All outputs except `req_ready` are registered.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned half/word accesses fault with cause 01 and issue no bus cycle.
- Undefined: misaligned accesses are aligned down and cause 01 is never produced.
  - Halfword ignores addr[0].
  - Word ignores addr[1:0] and uses lane 0, `be = 4'b1111`.

## Test plan
- LB, addr 0x1003, `mem_rdata=0x80FF_FF12` with immediate ack -> `mem_addr=0x1000`, `be=0000`; `rsp_data=0xFFFF_FF80` at cycle 2; `rsp_fault=0`.
- SH, addr 0x2002, wdata 0x1234_ABCD -> `mem_we=1`, `be=1100`, `mem_wdata=0xABCD_ABCD`; `rsp_valid` with `rsp_rd=0` after ack.
- LW, addr 0x3001, macro on -> no `mem_req`; `rsp_fault=1`, cause 01 at cycle 1. Macro off -> `mem_addr=0x3000`, `rsp_data=mem_rdata`.
- LHU, `TIMEOUT_CYCLES=4`, ack never given -> `mem_req` high cycles 1–4; `rsp_valid`, cause 10 at cycle 5. Repeat with ack at cycle 4 -> no fault.
- Store with funct3=100 -> cause 11 at cycle 1, no bus activity. Then LW accepted the cycle after RESP completes normally.
- `reset_n` low during BUS wait -> `mem_req`=0 next edge, no `rsp_valid`, `req_ready`=1 after release; a stray `mem_ack` in IDLE is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: one outstanding word-wide bus access with byte enables.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning down.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [4:0]  req_rd,
   output logic        rsp_valid,
   output logic [4:0]  rsp_rd,
   output logic [31:0] rsp_data,
   output logic        rsp_fault,
   output logic [1:0]  rsp_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   localparam logic [1:0] CauseNone     = 2'b00;
   localparam logic [1:0] CauseMisalign = 2'b01;
   localparam logic [1:0] CauseTimeout  = 2'b10;
   localparam logic [1:0] CauseIllegal  = 2'b11;
   localparam logic [7:0] CntLast       = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q, rd_d;
   logic        is_store_q, is_store_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [4:0]  rsp_rd_q, rsp_rd_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_fault_q, rsp_fault_d;
   logic [1:0]  rsp_cause_q, rsp_cause_d;

   logic        illegal;
   logic        misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   assign req_ready = (state_q == StIdle) && reset_n;

   // Legal widths: stores SB/SH/SW; loads LB/LH/LW/LBU/LHU.
   assign illegal = req_is_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Store lane replication and byte enables.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << req_addr[1:0];
            st_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = req_wdata;
         end
      endcase
   end

   // Load lane selection and extension, using the captured address and width.
   always_comb begin
      byte_lane = mem_rdata[7:0];
      case (addr_lo_q)
         2'b00:   byte_lane = mem_rdata[7:0];
         2'b01:   byte_lane = mem_rdata[15:8];
         2'b10:   byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
         3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
         3'b100:  load_data = {24'h000000, byte_lane};
         3'b101:  load_data = {16'h0000, half_lane};
         default: load_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_lo_d   = addr_lo_q;
      funct3_d    = funct3_q;
      rd_d        = rd_q;
      is_store_d  = is_store_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      rsp_valid_d = 1'b0;
      rsp_rd_d    = rsp_rd_q;
      rsp_data_d  = rsp_data_q;
      rsp_fault_d = rsp_fault_q;
      rsp_cause_d = rsp_cause_q;

      case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               addr_lo_d  = req_addr[1:0];
               funct3_d   = req_funct3;
               rd_d       = req_rd;
               is_store_d = req_is_store;
               if (illegal || misaligned) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_rd_d    = 5'd0;
                  rsp_data_d  = 32'd0;
                  rsp_fault_d = 1'b1;
                  rsp_cause_d = illegal ? CauseIllegal : CauseMisalign;
               end else begin
                  state_d     = StBus;
                  cnt_d       = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_is_store;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = req_is_store ? st_be : 4'b0000;
                  mem_wdata_d = req_is_store ? st_wdata : 32'd0;
               end
            end
         end
         StBus: begin
            // An ack in the expiry cycle takes priority over the timeout.
            if (mem_ack || (cnt_q == CntLast)) begin
               state_d     = StResp;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_be_d    = 4'b0000;
               rsp_valid_d = 1'b1;
               if (mem_ack) begin
                  rsp_rd_d    = is_store_q ? 5'd0 : rd_q;
                  rsp_data_d  = is_store_q ? 32'd0 : load_data;
                  rsp_fault_d = 1'b0;
                  rsp_cause_d = CauseNone;
               end else begin
                  rsp_rd_d    = 5'd0;
                  rsp_data_d  = 32'd0;
                  rsp_fault_d = 1'b1;
                  rsp_cause_d = CauseTimeout;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         addr_lo_q   <= 2'b00;
         funct3_q    <= 3'b000;
         rd_q        <= 5'd0;
         is_store_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_be_q    <= 4'b0000;
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= 5'd0;
         rsp_data_q  <= 32'd0;
         rsp_fault_q <= 1'b0;
         rsp_cause_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_lo_q   <= addr_lo_d;
         funct3_q    <= funct3_d;
         rd_q        <= rd_d;
         is_store_q  <= is_store_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_data_q  <= rsp_data_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_cause_q <= rsp_cause_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rd    = rsp_rd_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_fault = rsp_fault_q;
   assign rsp_cause = rsp_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4); honours LSU_MISALIGN_TRAP_EN if set.
module tb_load_store_unit;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [4:0]  req_rd;
   logic        rsp_valid;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data;
   logic        rsp_fault;
   logic [1:0]  rsp_cause;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   load_store_unit #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_is_store(req_is_store),
      .req_funct3  (req_funct3),
      .req_rd      (req_rd),
      .rsp_valid   (rsp_valid),
      .rsp_rd      (rsp_rd),
      .rsp_data    (rsp_data),
      .rsp_fault   (rsp_fault),
      .rsp_cause   (rsp_cause),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Present a request for cycle 0; returns at the start of cycle 1.
   task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wd;
      req_rd       = rd;
      req_valid    = 1'b1;
      #1;
      check_eq("req_ready_at_accept", req_ready, 1);
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      req_is_store = 1'b0;
      req_funct3   = 3'b000;
      req_rd       = 5'd0;
      mem_ack      = 1'b0;
      mem_rdata    = 32'd0;

      // Reset state
      repeat (2) tick();
      check_eq("rst_ready", req_ready, 0);
      check_eq("rst_mem_req", mem_req, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_mem_be", mem_be, 0);
      reset_n = 1'b1;
      #1;
      check_eq("rst_release_ready", req_ready, 1);
      tick();

      // LB from byte lane 3, sign-extended, immediate ack
      send(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd5);
      check_eq("lb_mem_req", mem_req, 1);
      check_eq("lb_mem_addr", mem_addr, 32'h0000_1000);
      check_eq("lb_mem_be", mem_be, 4'b0000);
      check_eq("lb_mem_we", mem_we, 0);
      check_eq("lb_ready_busy", req_ready, 0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h80FF_FF12;
      tick();
      mem_ack = 1'b0;
      check_eq("lb_rsp_valid", rsp_valid, 1);
      check_eq("lb_rsp_data", rsp_data, 32'hFFFF_FF80);
      check_eq("lb_rsp_fault", rsp_fault, 0);
      check_eq("lb_rsp_rd", rsp_rd, 5);
      check_eq("lb_mem_req_resp", mem_req, 0);
      check_eq("lb_ready_resp", req_ready, 0);
      tick();
      check_eq("lb_pulse_one", rsp_valid, 0);
      check_eq("lb_ready_after", req_ready, 1);

      // SH to upper half, ack after one wait cycle
      send(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd6);
      check_eq("sh_mem_we", mem_we, 1);
      check_eq("sh_mem_be", mem_be, 4'b1100);
      check_eq("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
      check_eq("sh_mem_addr", mem_addr, 32'h0000_2000);
      tick();
      check_eq("sh_req_held", mem_req, 1);
      check_eq("sh_be_held", mem_be, 4'b1100);
      check_eq("sh_no_rsp_yet", rsp_valid, 0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check_eq("sh_rsp_valid", rsp_valid, 1);
      check_eq("sh_rsp_rd", rsp_rd, 0);
      check_eq("sh_rsp_data", rsp_data, 0);
      check_eq("sh_rsp_fault", rsp_fault, 0);
      tick();

      // SB to lane 1
      send(1'b1, 3'b000, 32'h0000_6001, 32'h0000_00AB, 5'd1);
      check_eq("sb_mem_be", mem_be, 4'b0010);
      check_eq("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check_eq("sb_rsp_valid", rsp_valid, 1);
      tick();

      // LW at a misaligned address
      send(1'b0, 3'b010, 32'h0000_3001, 32'd0, 5'd8);
`ifdef LSU_MISALIGN_TRAP_EN
      check_eq("lwmis_mem_req", mem_req, 0);
      check_eq("lwmis_rsp_valid", rsp_valid, 1);
      check_eq("lwmis_rsp_fault", rsp_fault, 1);
      check_eq("lwmis_rsp_cause", rsp_cause, 2'b01);
      check_eq("lwmis_rsp_rd", rsp_rd, 0);
`else
      check_eq("lwmis_mem_req", mem_req, 1);
      check_eq("lwmis_mem_addr", mem_addr, 32'h0000_3000);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0;
      check_eq("lwmis_rsp_valid", rsp_valid, 1);
      check_eq("lwmis_rsp_data", rsp_data, 32'hDEAD_BEEF);
      check_eq("lwmis_rsp_fault", rsp_fault, 0);
      check_eq("lwmis_rsp_rd", rsp_rd, 8);
`endif
      tick();

      // LHU with no ack: timeout after 4 bus cycles
      send(1'b0, 3'b101, 32'h0000_4002, 32'd0, 5'd7);
      for (int c = 1; c <= 4; c++) begin
         check_eq($sformatf("to_mem_req_c%0d", c), mem_req, 1);
         check_eq($sformatf("to_no_rsp_c%0d", c), rsp_valid, 0);
         tick();
      end
      check_eq("to_rsp_valid", rsp_valid, 1);
      check_eq("to_rsp_fault", rsp_fault, 1);
      check_eq("to_rsp_cause", rsp_cause, 2'b10);
      check_eq("to_rsp_rd", rsp_rd, 0);
      check_eq("to_mem_req_off", mem_req, 0);
      tick();

      // LHU with ack in the expiry cycle: ack wins
      send(1'b0, 3'b101, 32'h0000_4002, 32'd0, 5'd7);
      repeat (3) tick();
      check_eq("ack4_mem_req", mem_req, 1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h8765_4321;
      tick();
      mem_ack = 1'b0;
      check_eq("ack4_rsp_valid", rsp_valid, 1);
      check_eq("ack4_rsp_fault", rsp_fault, 0);
      check_eq("ack4_rsp_cause", rsp_cause, 2'b00);
      check_eq("ack4_rsp_data", rsp_data, 32'h0000_8765);
      check_eq("ack4_rsp_rd", rsp_rd, 7);
      tick();

      // Store with illegal width, then LW right after the RESP pulse
      send(1'b1, 3'b100, 32'h0000_5004, 32'h0000_0011, 5'd3);
      check_eq("ill_rsp_valid", rsp_valid, 1);
      check_eq("ill_rsp_fault", rsp_fault, 1);
      check_eq("ill_rsp_cause", rsp_cause, 2'b11);
      check_eq("ill_mem_req", mem_req, 0);
      check_eq("ill_mem_we", mem_we, 0);
      tick();
      check_eq("ill_pulse_one", rsp_valid, 0);
      send(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd9);
      check_eq("lw_mem_req", mem_req, 1);
      check_eq("lw_mem_addr", mem_addr, 32'h0000_5000);
      mem_ack   = 1'b1;
      mem_rdata = 32'h0123_4567;
      tick();
      mem_ack = 1'b0;
      check_eq("lw_rsp_valid", rsp_valid, 1);
      check_eq("lw_rsp_data", rsp_data, 32'h0123_4567);
      check_eq("lw_rsp_rd", rsp_rd, 9);
      tick();

      // LH sign-extension from lower half
      send(1'b0, 3'b001, 32'h0000_7000, 32'd0, 5'd10);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_9ABC;
      tick();
      mem_ack = 1'b0;
      check_eq("lh_rsp_data", rsp_data, 32'hFFFF_9ABC);
      tick();

      // Reset during the bus wait, then a stray ack in IDLE
      send(1'b0, 3'b010, 32'h0000_8000, 32'd0, 5'd11);
      check_eq("rstbus_mem_req", mem_req, 1);
      tick();
      reset_n = 1'b0;
      tick();
      check_eq("rstbus_mem_req_drop", mem_req, 0);
      check_eq("rstbus_no_rsp", rsp_valid, 0);
      reset_n = 1'b1;
      #1;
      check_eq("rstbus_ready", req_ready, 1);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 1'b0;
      check_eq("stray_no_rsp", rsp_valid, 0);
      check_eq("stray_no_req", mem_req, 0);
      check_eq("stray_ready", req_ready, 1);
      tick();
      check_eq("stray_no_rsp_late", rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
